// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// instruction_fetch_unit: i281 fetch stage. PC, combinational code-ROM address,
// instruction register with valid/ready handoff to decode, and execute redirects.

module instruction_fetch_unit #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] code_addr,
  input  logic [DATA_W-1:0] code_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                halted_q, halted_d;
  logic [15:0]         count_q, count_d;
  logic                accept;
  logic                slot_free;

  assign accept    = ir_valid_q & ir_ready;
  assign slot_free = ~ir_valid_q | accept;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (accept) count_d = count_q + 16'd1;
        // A redirect flushes the slot and masks halt detection for this edge.
        if (redirect_valid) begin
          pc_d       = redirect_target;
          ir_valid_d = 1'b0;
        end else if (accept && (ir_q == HALT_WORD)) begin
          state_d    = S_HALTED;
          ir_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (slot_free && run) begin
          ir_d       = code_data;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
        end else if (slot_free) begin
          ir_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_HALTED: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  assign code_addr   = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// tb_instruction_fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural fetch model.

module tb_instruction_fetch_unit;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clock;
  logic        reset;
  logic        run;
  logic [4:0]  code_addr;
  logic [15:0] code_data;
  logic [15:0] ir;
  logic [4:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_target;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] rom [32];
  assign code_data = rom[code_addr];

  instruction_fetch_unit #(.ADDR_W(5), .DATA_W(16), .HALT_WORD(HALT)) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .code_addr      (code_addr),
    .code_data      (code_data),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 = paused, 1 = fetching, 2 = stopped on halt word.
  int          m_mode;
  logic [4:0]  m_pc, m_ir_pc;
  logic [15:0] m_ir, m_count;
  logic        m_valid, m_halted;
  bit          m_ok = 0;

  task automatic model_step();
    bit taken;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_ir = 0; m_ir_pc = 0;
      m_valid = 0; m_halted = 0; m_count = 0; m_ok = 1;
      return;
    end
    if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      taken = m_valid && ir_ready;
      if (taken) m_count = m_count + 16'd1;
      if (redirect_valid) begin
        m_pc = redirect_target;
        m_valid = 0;
      end else if (taken && m_ir == HALT) begin
        m_mode = 2; m_valid = 0; m_halted = 1;
      end else if (!m_valid || taken) begin
        if (run) begin
          m_ir = rom[m_pc];
          m_ir_pc = m_pc;
          m_valid = 1;
          m_pc = 5'((int'(m_pc) + 1) % 32);
        end else begin
          m_valid = 0;
          m_mode = 0;
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (m_ok) begin
      chk("code_addr",   code_addr,   m_pc);
      chk("ir_valid",    ir_valid,    m_valid);
      chk("halted",      halted,      m_halted);
      chk("fetch_count", fetch_count, m_count);
      if (m_valid) begin
        chk("ir",    ir,    m_ir);
        chk("ir_pc", ir_pc, m_ir_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1; run = 0; ir_ready = 0; redirect_valid = 0; redirect_target = 0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'h3000;
    rom[1] = 16'h8C08;
    tick(); tick();
    chk("rst_ir", ir, 16'h0000);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_addr", code_addr, 5'd0);
    chk("rst_count", fetch_count, 16'd0);
    chk("rst_halted", halted, 1'b0);

    reset = 0; run = 1; ir_ready = 1;
    tick();
    chk("e0_valid", ir_valid, 1'b0);
    tick();
    chk("e1_ir", ir, 16'h3000);
    chk("e1_irpc", ir_pc, 5'd0);
    chk("e1_valid", ir_valid, 1'b1);
    tick();
    chk("e2_ir", ir, 16'h8C08);
    chk("e2_irpc", ir_pc, 5'd1);
    chk("e2_count", fetch_count, 16'd1);

    ir_ready = 0;
    repeat (3) tick();
    chk("bp_ir", ir, 16'h8C08);
    chk("bp_irpc", ir_pc, 5'd1);
    chk("bp_addr", code_addr, 5'd2);
    chk("bp_count", fetch_count, 16'd1);
    ir_ready = 1;
    tick();
    chk("rel_ir", ir, 16'h1002);
    chk("rel_irpc", ir_pc, 5'd2);
    chk("rel_count", fetch_count, 16'd2);

    repeat (3) tick();
    chk("pre_redir_irpc", ir_pc, 5'd5);
    redirect_valid = 1; redirect_target = 5'd14;
    tick();
    chk("redir_valid", ir_valid, 1'b0);
    chk("redir_addr", code_addr, 5'd14);
    chk("redir_count", fetch_count, 16'd6);
    redirect_valid = 0;
    tick();
    chk("tgt_irpc", ir_pc, 5'd14);
    chk("tgt_ir", ir, 16'h100E);
    repeat (17) tick();
    chk("wrap_irpc31", ir_pc, 5'd31);
    chk("wrap_addr", code_addr, 5'd0);
    tick();
    chk("wrap_irpc0", ir_pc, 5'd0);

    rom[3] = HALT;
    repeat (3) tick();
    chk("halt_ir", ir, HALT);
    tick();
    chk("halt_flag", halted, 1'b1);
    chk("halt_valid", ir_valid, 1'b0);
    chk("halt_addr", code_addr, 5'd4);
    run = 0; redirect_valid = 1; redirect_target = 5'd9;
    repeat (3) tick();
    run = 1; redirect_valid = 0;
    tick();
    chk("halt_hold", halted, 1'b1);
    chk("halt_hold_addr", code_addr, 5'd4);

    reset = 1;
    tick();
    reset = 0;
    repeat (5) tick();
    chk("co_ir", ir, HALT);
    redirect_valid = 1; redirect_target = 5'd10;
    tick();
    chk("co_halted", halted, 1'b0);
    chk("co_addr", code_addr, 5'd10);
    redirect_valid = 0;
    tick();
    chk("co_irpc", ir_pc, 5'd10);
    chk("co_valid_pre_rst", ir_valid, 1'b1);

    reset = 1;
    tick();
    chk("mid_rst_valid", ir_valid, 1'b0);
    chk("mid_rst_ir", ir, 16'h0000);
    chk("mid_rst_count", fetch_count, 16'd0);
    chk("mid_rst_addr", code_addr, 5'd0);

    for (int i = 0; i < 32; i++)
      rom[i] = ($urandom_range(0, 11) == 0) ? HALT : 16'($urandom);
    tick();
    reset = 0;
    for (int c = 0; c < 4000; c++) begin
      run             = ($urandom_range(0, 9) != 0);
      ir_ready        = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = 5'($urandom);
      reset           = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
